// File: rtl/ecpa_pkg.sv
`default_nettype none
// ecpa_pkg: shared width, modular-multiplier state encoding and secp256k1 prime.
// Rev 1.0
package ecpa_pkg;

   localparam int WIDTH = 256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } modmul_state_t;

   localparam logic [255:0] c_SECP256K1_P =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

endpackage
`default_nettype wire

// File: rtl/modmul_step.sv
`default_nettype none
// modmul_step: one MSB-first iteration, R' = (2R + a_bit*b) mod m, assuming R < m and b < m.
// Rev 1.0
module modmul_step #(
   parameter int WIDTH = 256
) (
   input  logic [WIDTH-1:0] i_r,
   input  logic             i_a_bit,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_m,
   output logic [WIDTH-1:0] o_r_next
);

   logic [WIDTH:0]   w_m_ext;
   logic [WIDTH:0]   w_dbl;
   logic             w_dbl_ge;
   logic [WIDTH-1:0] w_r1;
   logic [WIDTH:0]   w_add;
   logic             w_add_ge;

   assign w_m_ext = {1'b0, i_m};

   // Both compares use the full WIDTH+1 value; the subtraction can then be
   // done on the low WIDTH bits because the true difference is below m.
   assign w_dbl    = {i_r, 1'b0};
   assign w_dbl_ge = (w_dbl >= w_m_ext);
   assign w_r1     = w_dbl_ge ? (w_dbl[WIDTH-1:0] - i_m) : w_dbl[WIDTH-1:0];

   assign w_add    = {1'b0, w_r1} + (i_a_bit ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
   assign w_add_ge = (w_add >= w_m_ext);
   assign o_r_next = w_add_ge ? (w_add[WIDTH-1:0] - i_m) : w_add[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/modular_multiplier.sv
`default_nettype none
// modular_multiplier: c = (a*b) mod m, interleaved shift-add-reduce, one bit of a per cycle.
// Rev 1.0
module modular_multiplier #(
   parameter int WIDTH = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] c,
   output logic             ready,
   output logic             busy,
   output logic             err
);
   import ecpa_pkg::*;

   localparam int             c_IW     = $clog2(WIDTH);
   localparam logic [c_IW-1:0] c_LAST_I = c_IW'(WIDTH - 1);

   modmul_state_t    r_state;
   modmul_state_t    w_state_nxt;
   logic             w_accept;
   logic             w_bad;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] w_r_nxt;
   logic [c_IW-1:0]  r_i;
   logic             r_err_next;
   logic [WIDTH-1:0] r_c;
   logic             r_ready;
   logic             r_busy;
   logic             r_err;

   // Operand check uses the live inputs because it is decided in the accepting cycle.
   assign w_bad = (m == '0) || (b >= m);

   modmul_step #(.WIDTH(WIDTH)) u_step (
      .i_r      (r_r),
      .i_a_bit  (r_a[r_i]),
      .i_b      (r_b),
      .i_m      (r_m),
      .o_r_next (w_r_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = w_bad ? DONE : ITER;
            end
         end
         ITER: begin
            if (r_i == '0) begin
               w_state_nxt = DONE;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a        <= '0;
         r_b        <= '0;
         r_m        <= '0;
         r_r        <= '0;
         r_i        <= '0;
         r_err_next <= 1'b0;
         r_c        <= '0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         if (w_accept) begin
            r_a        <= a;
            r_b        <= b;
            r_m        <= m;
            r_r        <= '0;
            r_i        <= c_LAST_I;
            r_err_next <= w_bad;
            r_busy     <= 1'b1;
         end
         if (r_state == ITER) begin
            r_r <= w_r_nxt;
            if (r_i != '0) begin
               r_i <= r_i - 1'b1;
            end
         end
         if (r_state == DONE) begin
            r_c     <= r_err_next ? '0 : r_r;
            r_err   <= r_err_next;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
         end
      end
   end

   assign c     = r_c;
   assign ready = r_ready;
   assign busy  = r_busy;
   assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_modular_multiplier.sv
`default_nettype none
// tb_modular_multiplier: directed and random checks of modular_multiplier against (a*b) mod m.
// Rev 1.0
module tb_modular_multiplier;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [255:0] a;
   logic [255:0] b;
   logic [255:0] m;
   logic [255:0] c;
   logic         ready;
   logic         busy;
   logic         err;

   int n_pass  = 0;
   int n_total = 0;

   modular_multiplier #(.WIDTH(256)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .m     (m),
      .c     (c),
      .ready (ready),
      .busy  (busy),
      .err   (err)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] model(input logic [255:0] ma, input logic [255:0] mb,
                                          input logic [255:0] mm);
      logic [511:0] p;
      p = {256'd0, ma} * {256'd0, mb};
      p = p % {256'd0, mm};
      return p[255:0];
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Issue one operation, release start after the accepting edge, wait for ready.
   task automatic do_op(input logic [255:0] ta, input logic [255:0] tb, input logic [255:0] tm,
                        output int lat, output logic busy0);
      @(negedge clk);
      a = ta; b = tb; m = tm; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      busy0 = busy;
      lat   = 0;
      while (!ready && lat < 400) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      int           lat;
      int           n_rdy;
      logic         busy0;
      logic [255:0] ra, rb, rm, p, exp_c;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; m = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_c", c, 256'd0);
      check("reset_ready", 256'(ready), 256'd0);
      check("reset_busy", 256'(busy), 256'd0);
      check("reset_err", 256'(err), 256'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op(256'd190, 256'd2, 256'd367, lat, busy0);
      check("t1_busy", 256'(busy0), 256'd1);
      check("t1_ready", 256'(ready), 256'd1);
      check("t1_latency", 256'(lat), 256'd257);
      check("t1_c", c, 256'd13);
      check("t1_err", 256'(err), 256'd0);
      check("t1_busy_at_ready", 256'(busy), 256'd0);

      do_op(256'd190, 256'd226, 256'd367, lat, busy0);
      check("t2_c_inverse", c, 256'd1);
      check("t2_err", 256'(err), 256'd0);

      p = ecpa_pkg::c_SECP256K1_P;
      do_op(p - 256'd1, p - 256'd1, p, lat, busy0);
      check("t3_secp_c", c, 256'd1);
      check("t3_latency", 256'(lat), 256'd257);

      do_op(256'd0, 256'd5, 256'd367, lat, busy0);
      check("t4_a0_c", c, 256'd0);
      check("t4_a0_latency", 256'(lat), 256'd257);

      do_op(256'd190, 256'd2, 256'd0, lat, busy0);
      check("t5_m0_err", 256'(err), 256'd1);
      check("t5_m0_c", c, 256'd0);
      check("t5_m0_latency", 256'(lat), 256'd1);

      do_op(256'd190, 256'd367, 256'd367, lat, busy0);
      check("t6_bgem_err", 256'(err), 256'd1);
      check("t6_bgem_c", c, 256'd0);

      do_op(rand256(), 256'd0, 256'd1, lat, busy0);
      check("t7_m1_c", c, 256'd0);
      check("t7_m1_err", 256'(err), 256'd0);

      for (int t = 0; t < 8; t++) begin
         ra = rand256();
         rm = (t < 4) ? rand256() : 256'($urandom_range(1, 100000));
         if (rm == '0) rm = 256'd1;
         rb = rand256() % rm;
         do_op(ra, rb, rm, lat, busy0);
         check($sformatf("rand%0d_c", t), c, model(ra, rb, rm));
         check($sformatf("rand%0d_err", t), 256'(err), 256'd0);
      end

      // start held high through the run, operands swapped after acceptance
      ra = rand256(); rm = p; rb = rand256() % rm;
      exp_c = model(ra, rb, rm);
      @(negedge clk);
      a = ra; b = rb; m = rm; start = 1'b1;
      @(posedge clk);
      #1;
      a = rand256(); b = 256'd3; m = 256'd367;
      lat = 0;
      while (!ready && lat < 400) begin
         @(posedge clk);
         #1;
         lat++;
      end
      start = 1'b0;
      check("hold_latency", 256'(lat), 256'd257);
      check("hold_c", c, exp_c);
      n_rdy = 0;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk);
         #1;
         if (ready) n_rdy++;
      end
      check("hold_extra_ready", 256'(n_rdy), 256'd0);
      check("hold_c_held", c, exp_c);

      // reset in the middle of ITER
      @(negedge clk);
      a = rand256(); b = 256'd7; m = p; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      check("midrst_busy_before", 256'(busy), 256'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_c", c, 256'd0);
      check("midrst_ready", 256'(ready), 256'd0);
      check("midrst_busy", 256'(busy), 256'd0);
      check("midrst_err", 256'(err), 256'd0);
      @(negedge clk);
      rst = 1'b0;
      n_rdy = 0;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk);
         #1;
         if (ready) n_rdy++;
      end
      check("midrst_no_ready", 256'(n_rdy), 256'd0);

      do_op(256'd190, 256'd2, 256'd367, lat, busy0);
      check("after_rst_c", c, 256'd13);
      check("after_rst_latency", 256'(lat), 256'd257);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
